vga_fb_fetch_arbiter: RTL and testbench
=======================================

Name: vga_fb_fetch_arbiter

Overview:
- Shares one single-port framebuffer memory between two requesters: the display line prefetch (high priority) and a pixel writer from the draw engine (low priority, bounded latency).
- On each line request from the VGA timing path, fetches H_VISIBLE pixels of the requested line into the line buffer that feeds the sync generator's pixel output.
- Grants writer cycles during gaps and in a fixed fairness slot while a fetch is running.

Parameters:
- H_VISIBLE, 800, pixels per visible line and reads per fetch.
- V_VISIBLE, 480, visible lines. Requests for line_num >= V_VISIBLE are ignored.
- ADDR_W, 19, framebuffer word address width.
- DATA_W, 16, pixel width.
- RD_LAT, 2, fixed memory read latency: mem_rd edge to mem_rdata valid edge (range 1..4).
- WR_SLOT, 4, fairness period. During a fetch, at most WR_SLOT-1 consecutive reads are issued before a pending write is granted.

Ports:
- clk  in  1  system clock; every register in the block uses this clock.
- reset  in  1  reset, asynchronous, active-high.
- line_req  in  1  one-cycle pulse: fetch line line_num.
- line_num  in  11  line index, sampled when line_req is high.
- wr_req  in  1  writer request; held high until wr_ack is seen.
- wr_addr  in  ADDR_W  write address; stable while wr_req is high.
- wr_data  in  DATA_W  write data; stable while wr_req is high.
- wr_ack  out  1  one-cycle pulse, high in the same cycle as the corresponding mem_wr.
- mem_addr  out  ADDR_W  registered memory address.
- mem_rd  out  1  registered read strobe.
- mem_wr  out  1  registered write strobe. Never high in the same cycle as mem_rd.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  read data, valid RD_LAT cycles after mem_rd.
- lb_we  out  1  line buffer write enable.
- lb_addr  out  11  line buffer pixel index, 0..H_VISIBLE-1.
- lb_data  out  DATA_W  line buffer write data.
- fetch_busy  out  1  high in FETCH or DRAIN.
- line_done  out  1  one-cycle pulse, one cycle after the final lb_we of a line.
- underrun  out  1  sticky flag: set when line_req arrives while fetch_busy is high; cleared only by reset.

Behaviour:
- Reset values: all outputs 0, state IDLE, read-return pipeline cleared. Reset mid-fetch drops all in-flight reads, so no lb_we is issued for them after reset.
- States:
  - IDLE, then FETCH on line_req with line_num < V_VISIBLE.
  - FETCH, then DRAIN once read H_VISIBLE-1 has been issued.
  - DRAIN, then IDLE once the last read has returned. line_done pulses in that cycle.
- Line base address: base = line_num * H_VISIBLE, truncated to ADDR_W bits and latched on line_req. Read x goes to address base + x, for x = 0..H_VISIBLE-1 in ascending order.
- Latency: line_req sampled at edge N, so the first mem_rd is high after edge N+2. lb_we for pixel x follows RD_LAT edges after its mem_rd, with lb_addr = x and lb_data = mem_rdata.
- Return tracking: an RD_LAT-deep shift register carries a valid bit and index x for each read. No handshake is used on the return path.
- Arbitration in FETCH:
  - A slot counter counts consecutive reads.
  - When the count reaches WR_SLOT-1 and a write is pending (wr_req && !wr_ack), the next cycle is a write instead of a read, and the counter clears.
  - When no write is pending, reads continue back to back and the counter saturates.
- Arbitration in IDLE and DRAIN: a pending write (wr_req && !wr_ack) is granted every cycle. In-flight reads are unaffected.
- Double-grant guard: the writer is never granted in a cycle where wr_ack is already high, which prevents granting the same request twice.
- Simultaneous events:
  - line_req and wr_req together in IDLE: the write is granted in that cycle and the fetch starts on the next cycle.
  - line_req while fetch_busy is high: the request is ignored and underrun is set.
  - line_req with line_num >= V_VISIBLE: no action and no flag.
- Fetch duration: 800 reads take 800 issue cycles with no writer. With wr_req held continuously they take 800 + floor(799/3) = 1066 issue cycles (WR_SLOT=4).

Test Plan:
- Reset, then line_req with line_num=2 and no writer -> mem_rd high for 800 consecutive cycles, addresses 1600..2399. lb_we follows 2 cycles later with lb_addr 0..799. line_done pulses once. fetch_busy is low afterwards.
- wr_req held continuously during a fetch of line 0 -> pattern RRRW repeats, giving 266 wr_ack pulses inside FETCH and 1066 issue cycles. mem_rd and mem_wr are never high together.
- Writer alone in IDLE issuing 5 back-to-back requests -> one wr_ack per request, and each mem_wr carries that request's wr_addr and wr_data.
- line_req during FETCH -> underrun=1, current fetch completes unchanged, no second fetch. line_req with line_num=480 in IDLE -> no mem_rd.
- Assert reset at read 400 of a fetch -> all outputs 0 immediately. After release, no lb_we from stale reads, state IDLE, and a new line_req fetches normally.
- Rerun the first scenario with RD_LAT=1 and RD_LAT=4 -> lb_we lags mem_rd by exactly RD_LAT cycles.

Source files
------------

// File: rtl/vga_fb_fetch_arbiter.sv
// Shares a single-port framebuffer between the display line prefetch (high priority)
// and the draw-engine pixel writer, which gets gaps and a fairness slot during a fetch.
`timescale 1ns/1ps
module vga_fb_fetch_arbiter #(
  parameter int H_VISIBLE = 800,
  parameter int V_VISIBLE = 480,
  parameter int ADDR_W    = 19,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int WR_SLOT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_req,
  input  logic [10:0]       line_num,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              lb_we,
  output logic [10:0]       lb_addr,
  output logic [DATA_W-1:0] lb_data,
  output logic              fetch_busy,
  output logic              line_done,
  output logic              underrun
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  localparam int             CW       = $clog2(WR_SLOT + 1);
  localparam logic [CW-1:0]  SLOT_MAX = CW'(WR_SLOT - 1);
  localparam logic [10:0]    LAST_X   = 11'(H_VISIBLE - 1);
  localparam logic [10:0]    V_LIM    = 11'(V_VISIBLE);
  localparam logic [31:0]    H32      = 32'(H_VISIBLE);

  state_t              state, state_next;
  logic                start_q;
  logic [ADDR_W-1:0]   base;
  logic [10:0]         rd_x;
  logic [10:0]         issue_x;
  logic [CW-1:0]       cnt;
  logic [RD_LAT-1:0]   pv;
  logic [10:0]         px [RD_LAT];
  logic                pending, accept, last_ret, do_rd, do_wr;
  logic [31:0]         prod;

  assign prod       = {21'd0, line_num} * H32;
  assign pending    = wr_req && !wr_ack;
  assign accept     = line_req && (line_num < V_LIM) && (state == IDLE) && !start_q;
  assign last_ret   = pv[RD_LAT-1] && (px[RD_LAT-1] == LAST_X);
  assign fetch_busy = (state != IDLE);
  assign lb_we      = pv[RD_LAT-1];
  assign lb_addr    = px[RD_LAT-1];
  assign lb_data    = lb_we ? mem_rdata : '0;

  always_comb begin
    state_next = state;
    do_rd      = 1'b0;
    do_wr      = 1'b0;
    unique case (state)
      IDLE: begin
        do_wr = pending;
        if (start_q) state_next = FETCH;
      end
      FETCH: begin
        // Reads run back to back; a waiting write steals the slot after WR_SLOT-1 reads.
        if (pending && (cnt == SLOT_MAX)) begin
          do_wr = 1'b1;
        end else begin
          do_rd = 1'b1;
          if (rd_x == LAST_X) state_next = DRAIN;
        end
      end
      DRAIN: begin
        do_wr = pending;
        if (last_ret) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      base      <= '0;
      rd_x      <= '0;
      issue_x   <= '0;
      cnt       <= '0;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      wr_ack    <= 1'b0;
      mem_wdata <= '0;
      line_done <= 1'b0;
      underrun  <= 1'b0;
      pv        <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) px[i] <= '0;
    end else begin
      state     <= state_next;
      start_q   <= accept;
      mem_rd    <= do_rd;
      mem_wr    <= do_wr;
      wr_ack    <= do_wr;
      line_done <= last_ret;
      if (line_req && fetch_busy) underrun <= 1'b1;
      if (accept) base <= prod[ADDR_W-1:0];

      if (state == IDLE) begin
        rd_x <= '0;
        cnt  <= '0;
      end
      if (do_rd) begin
        mem_addr <= base + ADDR_W'(rd_x);
        issue_x  <= rd_x;
        rd_x     <= rd_x + 11'd1;
        if (cnt != SLOT_MAX) cnt <= cnt + CW'(1);
      end
      if (do_wr) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
        if (state == FETCH) cnt <= '0;
      end

      // Stage 0 captures the registered strobe, so the last stage lines up with mem_rdata.
      pv[0] <= mem_rd;
      px[0] <= issue_x;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pv[i] <= pv[i-1];
        px[i] <= px[i-1];
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_fetch_arbiter.sv
// Scoreboard bench for vga_fb_fetch_arbiter: randomized lines and writer traffic
// against a queue-based reference model with a latency-accurate memory model.
`timescale 1ns/1ps
module tb_vga_fb_fetch_arbiter #(parameter int RD_LAT = 2);

  localparam int H  = 800;
  localparam int V  = 480;
  localparam int AW = 19;
  localparam int DW = 16;
  localparam int WS = 4;

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {logic [10:0] x; logic [DW-1:0] d;} lb_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          line_req = 1'b0;
  logic [10:0]   line_num = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack, mem_rd, mem_wr, lb_we, fetch_busy, line_done, underrun;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata, lb_data;
  logic [10:0]   lb_addr;

  vga_fb_fetch_arbiter #(.H_VISIBLE(H), .V_VISIBLE(V), .ADDR_W(AW), .DATA_W(DW),
                         .RD_LAT(RD_LAT), .WR_SLOT(WS)) dut (
    .clk(clk), .reset(reset), .line_req(line_req), .line_num(line_num),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .fetch_busy(fetch_busy), .line_done(line_done), .underrun(underrun));

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mdat(input logic [AW-1:0] a);
    logic [31:0] t;
    t = {13'd0, a} * 32'd2654435761;
    return t[31:16] ^ a[15:0];
  endfunction

  // Memory: data for the address seen with mem_rd appears RD_LAT edges later.
  logic [AW-1:0] pa [1:4];
  always @(posedge clk) begin
    pa[1] <= mem_addr; pa[2] <= pa[1]; pa[3] <= pa[2]; pa[4] <= pa[3];
  end
  assign mem_rdata = mdat(pa[RD_LAT]);

  int     n_checks = 0, n_pass = 0;
  wr_t    exp_wr[$];
  lb_t    exp_lb[$];
  logic [AW-1:0] exp_rd[$];
  longint rd_cyc[$];
  int     line_rd_cnt = 0, wr_between = 0, last_between = 0;
  longint first_rd_cyc = 0, last_first = 0, last_span = 0, req_cyc = 0;
  int     done_cnt = 0, ack_total = 0, rd_total = 0, lb_total = 0;
  bit     prev_last = 0, model_busy = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Returns whether the reference model expects the request to start a fetch.
  task automatic start_line(input int ln, output bit acc);
    logic [31:0] b;
    acc = (ln < V) && !model_busy;
    tick();
    line_num = 11'(ln);
    line_req = 1'b1;
    if (acc) begin
      model_busy = 1;
      b = (ln * H) % (1 << AW);
      for (int x = 0; x < H; x++) begin
        exp_rd.push_back(AW'(b + x));
        exp_lb.push_back('{x: 11'(x), d: mdat(AW'(b + x))});
      end
    end
    tick();
    req_cyc  = cyc;
    line_req = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int d0, t;
    d0 = done_cnt;
    t  = 0;
    while (done_cnt == d0 && t < 3000) begin tick(); t++; end
    if (t >= 3000) check({name, "_timeout"}, 0, 1);
    model_busy = 0;
  endtask

  task automatic writer(input int n, input int maxgap);
    int t, gap;
    for (int i = 0; i < n; i++) begin
      wr_addr = AW'($urandom);
      wr_data = DW'($urandom);
      wr_req  = 1'b1;
      exp_wr.push_back('{addr: wr_addr, data: wr_data});
      t = 0;
      do begin tick(); t++; end while (!wr_ack && t < 2000);
      if (t >= 2000) begin check("wr_ack_timeout", 0, 1); wr_req = 1'b0; return; end
      gap = $urandom_range(0, maxgap);
      if (gap > 0 || i == n - 1) begin
        wr_req = 1'b0;
        repeat (gap) tick();
      end
    end
  endtask

  initial begin
    bit acc;
    int r0, l0, a0, d0, ln, t;

    fork
      forever begin
        @(negedge clk);
        if (reset) begin
          exp_rd.delete(); exp_lb.delete(); rd_cyc.delete();
          line_rd_cnt = 0; wr_between = 0; prev_last = 0;
        end else begin
          if (mem_wr) begin
            wr_t w;
            check("rd_wr_exclusive", mem_rd, 0);
            check("wr_ack_with_mem_wr", wr_ack, 1);
            ack_total++;
            if (line_rd_cnt > 0) wr_between++;
            if (exp_wr.size() == 0) check("unexpected_mem_wr", 1, 0);
            else begin
              w = exp_wr.pop_front();
              check("mem_wr_addr", mem_addr, w.addr);
              check("mem_wdata", mem_wdata, w.data);
            end
          end else if (wr_ack) check("wr_ack_without_mem_wr", 1, 0);
          if (mem_rd) begin
            rd_total++;
            if (exp_rd.size() == 0) check("unexpected_mem_rd", 1, 0);
            else check("mem_rd_addr", mem_addr, exp_rd.pop_front());
            rd_cyc.push_back(cyc);
            if (line_rd_cnt == 0) first_rd_cyc = cyc;
            line_rd_cnt++;
            if (line_rd_cnt == H) begin
              last_span = cyc - first_rd_cyc + 1;
              last_first = first_rd_cyc;
              last_between = wr_between;
              line_rd_cnt = 0;
              wr_between = 0;
            end
          end
          if (lb_we) begin
            lb_t e;
            lb_total++;
            if (exp_lb.size() == 0 || rd_cyc.size() == 0) check("unexpected_lb_we", 1, 0);
            else begin
              e = exp_lb.pop_front();
              check("lb_addr", lb_addr, e.x);
              check("lb_data", lb_data, e.d);
              check("lb_we_lag", cyc - rd_cyc.pop_front(), RD_LAT);
            end
          end
          if (line_done) begin
            done_cnt++;
            check("line_done_after_last_lb_we", prev_last, 1);
          end
          prev_last = lb_we && (lb_addr == 11'(H - 1));
        end
      end
    join_none

    repeat (3) tick();
    check("reset_outputs", {mem_rd, mem_wr, wr_ack, lb_we, line_done, fetch_busy, underrun,
                            mem_addr, mem_wdata, lb_addr, lb_data}, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Plain fetch of line 2.
    start_line(2, acc);
    wait_done("line2");
    check("line2_first_rd_latency", last_first - req_cyc, 2);
    check("line2_issue_span", last_span, H);
    check("line2_busy_after", fetch_busy, 0);
    check("line2_rd_left", exp_rd.size(), 0);
    check("line2_lb_left", exp_lb.size(), 0);

    // Writer held continuously across a fetch of line 0.
    d0 = done_cnt;
    fork
      writer(320, 0);
      begin start_line(0, acc); wait_done("line0"); end
    join
    repeat (5) tick();
    check("line0_issue_span", last_span, H + (H - 1) / (WS - 1));
    check("line0_writes_in_fetch", last_between, (H - 1) / (WS - 1));
    check("line0_done_count", done_cnt - d0, 1);

    // Writer alone in IDLE.
    a0 = ack_total;
    writer(5, 0);
    repeat (3) tick();
    check("idle_ack_count", ack_total - a0, 5);

    // line_req during FETCH, then an out-of-range line.
    check("underrun_clear", underrun, 0);
    d0 = done_cnt;
    ln = $urandom_range(0, V - 1);
    start_line(ln, acc);
    repeat (100) tick();
    start_line((ln + 7) % V, acc);
    check("second_req_rejected", acc, 0);
    check("underrun_set", underrun, 1);
    wait_done("underrun_line");
    repeat (20) tick();
    check("underrun_single_fetch", done_cnt - d0, 1);
    r0 = rd_total;
    start_line(V, acc);
    repeat (20) tick();
    check("out_of_range_no_rd", rd_total - r0, 0);
    check("out_of_range_no_busy", fetch_busy, 0);
    check("underrun_sticky", underrun, 1);

    // Random lines with a bursty writer.
    fork
      writer(60, 6);
      for (int k = 0; k < 3; k++) begin
        start_line($urandom_range(0, V - 1), acc);
        wait_done("rand_line");
        repeat ($urandom_range(0, 10)) tick();
      end
    join
    repeat (10) tick();
    check("rand_wr_left", exp_wr.size(), 0);
    check("rand_rd_left", exp_rd.size(), 0);

    // Reset in the middle of a fetch.
    start_line($urandom_range(0, V - 1), acc);
    t = 0;
    while (line_rd_cnt < 400 && t < 2000) begin tick(); t++; end
    if (t >= 2000) check("reach_read_400_timeout", 0, 1);
    reset = 1'b1;
    #1;
    check("midreset_outputs", {mem_rd, mem_wr, wr_ack, lb_we, line_done, fetch_busy, underrun,
                               mem_addr, mem_wdata, lb_addr, lb_data}, 0);
    repeat (3) tick();
    reset = 1'b0;
    model_busy = 0;
    l0 = lb_total;
    repeat (10) tick();
    check("midreset_no_stale_lb_we", lb_total - l0, 0);
    check("midreset_idle", fetch_busy, 0);
    start_line(5, acc);
    wait_done("after_reset");
    check("after_reset_span", last_span, H);
    check("after_reset_lb_left", exp_lb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
